// File: rtl/img_loader.sv
// Image loader: buffers IMG_SIZE pixel words, runs the CNN core on them,
// then holds the prediction (or a timeout abort) until downstream takes it.
module img_loader #(
    parameter int IMG_SIZE = 64,
    parameter int DATA_W   = 32,
    parameter int OUT_W    = 32,
    parameter int TIMEOUT  = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    output logic [IMG_SIZE*DATA_W-1:0] img_flat,
    output logic                       cnn_enable,
    input  logic                       cnn_done,
    input  logic [OUT_W-1:0]           cnn_value,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [OUT_W-1:0]           res_value,
    output logic                       res_err
);

    localparam int CNT_W = $clog2(IMG_SIZE) + 1;
    localparam int RUN_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {LOAD, RUN, RESULT} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [RUN_W-1:0]  run_cnt;
    logic [DATA_W-1:0] img_buf [IMG_SIZE];
    logic              accept;
    logic              last_word;
    logic              timeout_hit;

    always_comb begin
        accept      = (state == LOAD) && s_valid;
        last_word   = accept && (cnt == CNT_W'(IMG_SIZE - 1));
        timeout_hit = (run_cnt == RUN_W'(TIMEOUT - 1));
        s_ready     = (state == LOAD);
        res_valid   = (state == RESULT);
        state_nxt   = state;
        case (state)
            LOAD:    if (last_word) state_nxt = RUN;
            RUN:     if (cnn_done || timeout_hit) state_nxt = RESULT;
            RESULT:  if (res_ready) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        img_flat = '0;
        for (int i = 0; i < IMG_SIZE; i++) begin
            img_flat[DATA_W*i +: DATA_W] = img_buf[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            cnt        <= '0;
            run_cnt    <= '0;
            cnn_enable <= 1'b0;
            res_value  <= '0;
            res_err    <= 1'b0;
            for (int i = 0; i < IMG_SIZE; i++) begin
                img_buf[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            // Only the addressed word changes; the rest persist across images.
            for (int i = 0; i < IMG_SIZE; i++) begin
                if (accept && (cnt == CNT_W'(i))) img_buf[i] <= s_data;
            end
            case (state)
                LOAD: begin
                    if (accept) cnt <= last_word ? '0 : cnt + 1'b1;
                    if (last_word) begin
                        cnn_enable <= 1'b1;
                        run_cnt    <= '0;
                    end
                end
                RUN: begin
                    run_cnt <= run_cnt + 1'b1;
                    // A result arriving on the timeout cycle still counts as a real result.
                    if (cnn_done) begin
                        res_value  <= cnn_value;
                        res_err    <= 1'b0;
                        cnn_enable <= 1'b0;
                    end else if (timeout_hit) begin
                        res_value  <= '0;
                        res_err    <= 1'b1;
                        cnn_enable <= 1'b0;
                    end
                end
                RESULT: begin
                    if (res_ready) cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_img_loader.sv
// Bench for img_loader: transaction-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_img_loader;

    localparam int IMG = 64;
    localparam int DW  = 32;
    localparam int OW  = 32;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic [IMG*DW-1:0] img_flat;
    logic              cnn_enable;
    logic              cnn_done;
    logic [OW-1:0]     cnn_value;
    logic              res_valid;
    logic              res_ready;
    logic [OW-1:0]     res_value;
    logic              res_err;

    img_loader #(.IMG_SIZE(IMG), .DATA_W(DW), .OUT_W(OW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .img_flat(img_flat), .cnn_enable(cnn_enable), .cnn_done(cnn_done),
        .cnn_value(cnn_value), .res_valid(res_valid), .res_ready(res_ready),
        .res_value(res_value), .res_err(res_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int dut_accepts = 0;
    bit chk_on = 1'b0;

    // Model state: phase 0 = loading, 1 = CNN running, 2 = result held.
    int          m_phase;
    int          m_n;
    int          m_age;
    logic [DW-1:0] m_img [IMG];
    logic [OW-1:0] m_val;
    logic          m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input int idx, input logic [DW-1:0] exp);
        check(name, 64'(img_flat[DW*idx +: DW]), 64'(exp));
    endtask

    function automatic logic [IMG*DW-1:0] model_flat();
        logic [IMG*DW-1:0] r;
        for (int i = 0; i < IMG; i++) r[DW*i +: DW] = m_img[i];
        return r;
    endfunction

    task automatic check_img(input string name, input logic [IMG*DW-1:0] exp);
        n_checks++;
        if (img_flat !== exp) begin
            n_errs++;
            for (int i = 0; i < IMG; i++) begin
                if (img_flat[DW*i +: DW] !== exp[DW*i +: DW]) begin
                    $display("FAIL %s: word %0d got %0h expected %0h at %0t", name, i,
                             img_flat[DW*i +: DW], exp[DW*i +: DW], $time);
                    break;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_n = 0; m_age = 0; m_val = '0; m_err = 1'b0;
            for (int i = 0; i < IMG; i++) m_img[i] = '0;
        end else begin
            case (m_phase)
                0: if (s_valid) begin
                    m_img[m_n] = s_data;
                    m_n++;
                    if (m_n == IMG) begin m_n = 0; m_phase = 1; m_age = 0; end
                end
                1: begin
                    if (cnn_done) begin
                        m_val = cnn_value; m_err = 1'b0; m_phase = 2;
                    end else if (m_age == TO - 1) begin
                        m_val = '0; m_err = 1'b1; m_phase = 2;
                    end
                    m_age++;
                end
                default: if (res_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("s_ready", 64'(s_ready), 64'(m_phase == 0));
            check("cnn_enable", 64'(cnn_enable), 64'(m_phase == 1));
            check("res_valid", 64'(res_valid), 64'(m_phase == 2));
            check("res_value", 64'(res_value), 64'(m_val));
            check("res_err", 64'(res_err), 64'(m_err));
            check_img("img_flat", model_flat());
            if (s_valid && s_ready) dut_accepts++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_burst(input int n, input logic [DW-1:0] base, input logic [DW-1:0] inc);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = base + inc * DW'(i);
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; cnn_done = 1'b0;
        cnn_value = '0; res_ready = 1'b0;
        step();
        chk_on = 1'b1;
        step();
        check("reset s_ready", 64'(s_ready), 64'd1);
        check("reset res_valid", 64'(res_valid), 64'd0);
        check_img("reset img_flat", '0);
        rst = 1'b0;
        step();

        // 64 ones with s_valid held high
        load_burst(IMG, 32'd1, 32'd0);
        check("burst s_ready low", 64'(s_ready), 64'd0);
        check("burst cnn_enable", 64'(cnn_enable), 64'd1);
        check_word("burst word0", 0, 32'd1);
        check_word("burst word63", 63, 32'd1);
        repeat (3) step();
        cnn_done = 1'b1; cnn_value = 32'd7;
        step();
        cnn_done = 1'b0; cnn_value = '0;
        check("done res_valid", 64'(res_valid), 64'd1);
        check("done res_value", 64'(res_value), 64'd7);
        check("done res_err", 64'(res_err), 64'd0);
        check("done cnn_enable", 64'(cnn_enable), 64'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("hold res_value", 64'(res_value), 64'd7);
            check("hold res_valid", 64'(res_valid), 64'd1);
        end
        handshake();
        check("back s_ready", 64'(s_ready), 64'd1);
        check("back res_valid", 64'(res_valid), 64'd0);
        cnn_done = 1'b1; cnn_value = 32'd99;
        step();
        cnn_done = 1'b0;
        check("load done ignored", 64'(res_value), 64'd7);
        check("load done no valid", 64'(res_valid), 64'd0);

        // Ramp with toggling s_valid, then let it time out
        acc0 = dut_accepts;
        for (int i = 0; i < IMG; i++) begin
            if (i > 0) begin
                s_valid = 1'b0; s_data = 32'hDEAD_BEEF;
                step();
            end
            s_valid = 1'b1; s_data = DW'(i);
            step();
        end
        s_valid = 1'b0;
        check("ramp accepts", 64'(dut_accepts - acc0), 64'd64);
        check_word("ramp word0", 0, 32'd0);
        check_word("ramp word37", 37, 32'd37);
        check_word("ramp word63", 63, 32'd63);
        repeat (TO - 1) step();
        check("pre-timeout res_valid", 64'(res_valid), 64'd0);
        step();
        check("timeout res_valid", 64'(res_valid), 64'd1);
        check("timeout res_err", 64'(res_err), 64'd1);
        check("timeout res_value", 64'(res_value), 64'd0);
        handshake();

        // cnn_done on the timeout cycle
        load_burst(IMG, 32'd5, 32'd3);
        check_word("mul3 word10", 10, 32'd35);
        repeat (TO - 1) step();
        cnn_done = 1'b1; cnn_value = 32'h55AA;
        step();
        cnn_done = 1'b0;
        check("tie res_valid", 64'(res_valid), 64'd1);
        check("tie res_err", 64'(res_err), 64'd0);
        check("tie res_value", 64'(res_value), 64'h55AA);
        handshake();

        // Reset mid-load, then a clean image
        load_burst(30, 32'hA0, 32'd1);
        check_word("partial word29", 29, 32'hBD);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_img("mid-load reset img", '0);
        check("mid-load reset s_ready", 64'(s_ready), 64'd1);
        check("mid-load reset res_value", 64'(res_value), 64'd0);
        load_burst(IMG, 32'h1000, 32'd1);
        check_word("fresh word0", 0, 32'h1000);
        check_word("fresh word63", 63, 32'h103F);
        check("fresh cnn_enable", 64'(cnn_enable), 64'd1);
        step();
        cnn_done = 1'b1; cnn_value = 32'd3;
        step();
        cnn_value = 32'hBEEF;
        step();
        cnn_done = 1'b0;
        check("result done ignored", 64'(res_value), 64'd3);
        handshake();
        step();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
